// File: rtl/region_redraw_pkg.sv
// Shared constants for the rectangle redraw engine: screen geometry, modes,
// controller state encoding and colour defaults.
package region_redraw_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned COLOUR_W = 3;

    localparam logic MODE_RESTORE = 1'b0;
    localparam logic MODE_FILL    = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [COLOUR_W-1:0] BLACK = '0;

endpackage

// File: rtl/region_redraw_if.sv
// Bundle of the control handshake, background ROM port and VGA plot port.
// master: game control / ROM / VGA side; slave: the redraw engine.
interface region_redraw_if #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COLOUR_W = region_redraw_pkg::COLOUR_W,
    parameter int unsigned ADDR_W   = 15
);
    logic                start;
    logic                mode;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] fill_colour;
    logic [ADDR_W-1:0]   rom_addr;
    logic [COLOUR_W-1:0] rom_q;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOUR_W-1:0] colour_out;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output start, mode, x0, y0, w, h, fill_colour, rom_q,
        input  rom_addr, x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
        input  start, mode, x0, y0, w, h, fill_colour, rom_q,
        output rom_addr, x_out, y_out, colour_out, plot, busy, done
    );

endinterface

// File: rtl/region_redraw_pipe.sv
// Delay line carrying {valid, in-bounds, x, y} alongside the ROM read so the
// pixel coordinates line up with the returned ROM data.
module region_redraw_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           in_valid,
    input  logic           in_inb,
    input  logic [X_W-1:0] in_x,
    input  logic [Y_W-1:0] in_y,
    output logic           out_valid,
    output logic           out_inb,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] inb_q;
    logic [X_W-1:0]   x_q [DEPTH];
    logic [Y_W-1:0]   y_q [DEPTH];

    // Shift every stage by one per cycle; reset empties the line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            inb_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            inb_q[0]   <= in_inb;
            x_q[0]     <= in_x;
            y_q[0]     <= in_y;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                inb_q[i]   <= inb_q[i-1];
                x_q[i]     <= x_q[i-1];
                y_q[i]     <= y_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_inb   = inb_q[DEPTH-1];
    assign out_x     = x_q[DEPTH-1];
    assign out_y     = y_q[DEPTH-1];

endmodule

// File: rtl/region_redraw.sv
// Rectangle redraw engine: walks a latched rectangle in raster order, one
// pixel per cycle, plotting either background-ROM colour or a fill colour.
module region_redraw #(
    parameter int unsigned SCREEN_W    = 160,
    parameter int unsigned SCREEN_H    = 120,
    parameter int unsigned X_W         = 8,
    parameter int unsigned Y_W         = 7,
    parameter int unsigned COLOUR_W    = 3,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned ROM_LATENCY = 1
) (
    input logic             clk,
    input logic             resetn,
    region_redraw_if.slave  bus
);
    import region_redraw_pkg::*;

    localparam int unsigned CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

    logic [1:0]          state_q, state_d;
    logic                mode_q;
    logic [X_W-1:0]      x0_q, w_q;
    logic [Y_W-1:0]      y0_q, h_q;
    logic [COLOUR_W-1:0] fill_q;
    logic [X_W:0]        x_q, x_end;
    logic [Y_W:0]        y_q, y_end;
    logic [CNT_W-1:0]    cnt_q;
    logic                x_last, y_last, inb, scanning;

    logic                p_valid, p_inb;
    logic [X_W-1:0]      p_x, x_hold_q;
    logic [Y_W-1:0]      p_y, y_hold_q;
    logic [COLOUR_W-1:0] cur_colour, c_hold_q;
    logic                plot;

    // One bit wider than the coordinates so the walk never wraps.
    assign x_end    = {1'b0, x0_q} + {1'b0, w_q} - (X_W+1)'(1);
    assign y_end    = {1'b0, y0_q} + {1'b0, h_q} - (Y_W+1)'(1);
    assign x_last   = (x_q == x_end);
    assign y_last   = (y_q == y_end);
    assign inb      = (x_q < X_LIM) && (y_q < Y_LIM);
    assign scanning = (state_q == ST_SCAN);

    // Next-state decode for the walk controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) begin
                state_d = (bus.w == '0 || bus.h == '0) ? ST_DONE : ST_SCAN;
            end
            ST_SCAN:  if (x_last && y_last) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == '0) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Controller state, latched request and raster counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RESTORE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            fill_q  <= BLACK;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    mode_q <= bus.mode;
                    x0_q   <= bus.x0;
                    y0_q   <= bus.y0;
                    w_q    <= bus.w;
                    h_q    <= bus.h;
                    fill_q <= bus.fill_colour;
                    x_q    <= {1'b0, bus.x0};
                    y_q    <= {1'b0, bus.y0};
                end
                ST_SCAN: begin
                    if (x_last) begin
                        x_q <= {1'b0, x0_q};
                        y_q <= y_q + 1'b1;
                    end else begin
                        x_q <= x_q + 1'b1;
                    end
                    // Drain length: last pixel still has ROM_LATENCY cycles to emerge.
                    cnt_q <= CNT_W'(ROM_LATENCY - 1);
                end
                ST_DRAIN: cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // ROM address for the pixel being issued; clipped pixels read address 0.
    always_comb begin
        bus.rom_addr = '0;
        if (scanning && inb) begin
            bus.rom_addr = ADDR_W'(y_q) * ADDR_W'(SCREEN_W) + ADDR_W'(x_q);
        end
    end

    region_redraw_pipe #(
        .DEPTH (ROM_LATENCY),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (scanning),
        .in_inb    (inb),
        .in_x      (x_q[X_W-1:0]),
        .in_y      (y_q[Y_W-1:0]),
        .out_valid (p_valid),
        .out_inb   (p_inb),
        .out_x     (p_x),
        .out_y     (p_y)
    );

    assign plot       = p_valid && p_inb;
    assign cur_colour = (mode_q == MODE_FILL) ? fill_q : bus.rom_q;

    // Remember the last plotted pixel so the VGA outputs hold between plots.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_hold_q <= '0;
            y_hold_q <= '0;
            c_hold_q <= BLACK;
        end else if (plot) begin
            x_hold_q <= p_x;
            y_hold_q <= p_y;
            c_hold_q <= cur_colour;
        end
    end

    assign bus.plot       = plot;
    assign bus.x_out      = plot ? p_x : x_hold_q;
    assign bus.y_out      = plot ? p_y : y_hold_q;
    assign bus.colour_out = plot ? cur_colour : c_hold_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);

endmodule

// File: doc/region_redraw.md
Name: region_redraw

Overview:
Parametrised rectangle redraw engine; successor to the full-screen background erase.
- On a start pulse it walks a caller-specified rectangle in raster order.
- Per pixel it emits either the background-ROM colour (restore mode) or a constant colour (fill mode) to the VGA plot interface.
- Sits between the game-control FSM (start/done handshake) and the VGA adapter. Drives the background ROM address and absorbs its read latency.

Parameters:
SCREEN_W, 160, screen width in pixels; also the ROM row stride
SCREEN_H, 120, screen height in pixels
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
COLOUR_W, 3, colour width
ADDR_W, 15, background ROM address width
ROM_LATENCY, 1, ROM read latency in cycles (>=1)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
mode  in  1  0 = restore from background ROM, 1 = solid fill
x0  in  X_W  rectangle left column
y0  in  Y_W  rectangle top row
w  in  X_W  rectangle width in pixels
h  in  Y_W  rectangle height in pixels
fill_colour  in  COLOUR_W  colour used when mode=1
rom_addr  out  ADDR_W  background ROM address
rom_q  in  COLOUR_W  background ROM data, ROM_LATENCY cycles after rom_addr
x_out  out  X_W  pixel x to VGA
y_out  out  Y_W  pixel y to VGA
colour_out  out  COLOUR_W  pixel colour to VGA
plot  out  1  VGA write enable, one pixel per high cycle
busy  out  1  high from acceptance until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous and active-low. All outputs go to 0 and state goes to IDLE. Reset asserted mid-operation aborts the walk: no further plot and no done.
- States:
  - IDLE: wait for start.
  - SCAN: issue one pixel per cycle.
  - DRAIN: wait ROM_LATENCY cycles for the pipeline to empty.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Acceptance: start=1 at edge 0 in IDLE latches mode, x0, y0, w, h and fill_colour. Input changes after acceptance have no effect. start is ignored while busy=1.
- Zero-size rectangle (w==0 or h==0): go IDLE->DONE. done is high in cycle 1. No plot.
- SCAN order: columns x0..x0+w-1 within each row; rows y0..y0+h-1. Pixel n (n=0..N-1, N=w*h) has its address presented in cycle 1+n.
- Coordinate arithmetic: computed at X_W+1 / Y_W+1 bits, so there is no wrap-around.
- rom_addr = y*SCREEN_W + x, truncated to ADDR_W. The address is driven for every pixel in both modes.
- Pipeline:
  - x, y, valid and in-bounds travel through a ROM_LATENCY-stage shift register.
  - Pixel n appears on x_out/y_out/colour_out with plot=1 in cycle 1+n+ROM_LATENCY.
  - colour_out = rom_q when mode=0, else fill_colour.
- Clipping: pixels with x>=SCREEN_W or y>=SCREEN_H still consume their cycle but produce plot=0. rom_addr is held at 0 for those pixels.
- done timing: done=1 in cycle N+ROM_LATENCY+1.
- busy: high from cycle 1 through the done cycle inclusive.
- Hold rules: x_out, y_out and colour_out hold their last values when plot=0.

Decomposition:
- Shared package:
  - screen constants SCREEN_W and SCREEN_H
  - mode encodings MODE_RESTORE=0 and MODE_FILL=1
  - state encoding IDLE/SCAN/DRAIN/DONE
  - COLOUR_W and the BLACK constant
- One natural sub-module, redraw_pipe:
  - parametrised ROM_LATENCY-deep shift register carrying {valid, inb, x, y}
  - async active-low reset clears all valid bits

Test Plan:
- Full-screen restore: x0=0, y0=0, w=160, h=120, mode=0, ROM_LATENCY=1, ROM model returns addr[2:0].
  - Exactly 19200 plots.
  - Pixel (159,119) has colour 19199[2:0]=7.
  - done in cycle 19202.
- Fill: x0=10, y0=20, w=3, h=2, colour=5.
  - Plots in cycles 2..7, in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all colour 5.
  - done in cycle 8; busy low in cycle 9.
- Clipping: x0=158, y0=118, w=4, h=4, mode=1.
  - Only (158,118),(159,118),(158,119),(159,119) plotted.
  - done in cycle 18.
- Latency and zero size:
  - ROM_LATENCY=3, 2x1 restore: colours match the ROM model, plots in cycles 4..5, done in cycle 6.
  - w=0: no plot, done in cycle 1.
- Handshake and reset:
  - start re-pulsed while busy with different x0: ignored, the original rectangle completes.
  - resetn dropped mid-SCAN: outputs 0 immediately, no done; a fresh start after release works.
